gs_host_mailbox: RTL and testbench
==================================

GS_HOST_MAILBOX -- requirements
Module: gs_host_mailbox

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, host-to-GS data FIFO depth in bytes; it is a power of two, 2..8.
REQ-002 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 The block SHALL have port clkcpu  input  1  Z80 clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port a  input  8  Z80 address low byte.
REQ-005 The block SHALL have port d_in  input  8  Z80 data bus, sampled on writes.
REQ-006 The block SHALL have port d_out  output  8  read data for the Z80 bus.
REQ-007 The block SHALL have port d_oe  output  1  d_out drive enable, active-high.
REQ-008 The block SHALL have ports n_iorq, n_rd, n_wr, n_m1  input  1 each  Z80 strobes, active-low.
REQ-009 The block SHALL have port ena  input  1  block enable (GS config bit).
REQ-010 The block SHALL have port iorqge  output  1  high when ena=1 and a=B3h or BBh.
REQ-011 The block SHALL have port gs_data  output  8  FIFO head byte.
REQ-012 The block SHALL have port gs_data_valid  output  1  FIFO not empty.
REQ-013 The block SHALL have port gs_data_pop  input  1  one-cycle pulse that removes the FIFO head.
REQ-014 The block SHALL have port gs_cmd  output  8  last host command byte.
REQ-015 The block SHALL have port gs_cmd_valid  output  1  command pending flag.
REQ-016 The block SHALL have port gs_cmd_ack  input  1  one-cycle pulse that clears the command flag.
REQ-017 The block SHALL have ports gs_out_wr (input, 1, pulse) and gs_out_data (input, 8, GS-to-host byte, captured on gs_out_wr).

Function
REQ-018 A qualified write SHALL be ~n_iorq & ~n_wr & n_m1 & ena, and a qualified read SHALL be ~n_iorq & ~n_rd & n_m1 & ena.
REQ-019 Each access SHALL be edge-detected against a registered copy, so that exactly one write or read event occurs per I/O cycle, on the first rising clkcpu edge where the access is qualified.
REQ-020 A write event to B3h SHALL push d_in into the FIFO when count<DEPTH; when the FIFO is full the byte SHALL be dropped and the sticky flag ovf SHALL be set.
REQ-021 A write event to BBh SHALL load gs_cmd<=d_in and set gs_cmd_valid=1.
REQ-022 d_oe SHALL be driven combinationally, as a qualified read & (a=B3h | a=BBh).
REQ-023 d_out SHALL be out_reg for B3h and status for BBh.
REQ-024 status SHALL be {out_flag, full, ovf, cnt[2:0], gs_data_valid, gs_cmd_valid}, with cnt = FIFO count 0..DEPTH (DEPTH=8 saturates the field at 7).
REQ-025 A read event on B3h SHALL clear out_flag, and a read event on BBh SHALL clear ovf.
REQ-026 gs_data_pop with FIFO not empty SHALL advance the read pointer; gs_data_pop on an empty FIFO SHALL be ignored.
REQ-027 When push and pop occur in the same cycle the count SHALL be unchanged; when the FIFO is full, that push SHALL be accepted and ovf SHALL NOT be set.
REQ-028 Pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH or go below 0.
REQ-029 gs_out_wr SHALL load out_reg<=gs_out_data and set out_flag=1; when it coincides with a host B3h read event, out_flag SHALL remain 1 and d_out SHALL show the old out_reg in that cycle.
REQ-030 When a host BBh write coincides with gs_cmd_ack, gs_cmd_valid SHALL remain 1 and gs_cmd SHALL take the new byte.
REQ-031 gs_data SHALL equal the FIFO head combinationally; its value is don't-care when gs_data_valid=0.
REQ-032 When ena=0, the block SHALL generate no host events and SHALL drive d_oe=0 and iorqge=0, while the GS-side ports keep operating.

Reset
REQ-033 rst_n=0 SHALL asynchronously clear the FIFO pointers, count, ovf, out_flag, out_reg, gs_cmd, gs_cmd_valid, and the edge-detect registers.
REQ-034 Because the edge-detect registers are cleared, an I/O cycle in progress at reset release SHALL be taken as a new event; FIFO contents are lost on reset.

Verification
REQ-035 The bench SHALL cover: reset, then write 11h,22h to B3h -> gs_data=11h, status cnt=2; one pop -> gs_data=22h.
REQ-036 The bench SHALL cover: write 5 bytes with DEPTH=4 -> full=1, ovf=1, 5th byte absent; then BBh read -> ovf=0, full=1.
REQ-037 The bench SHALL cover: full FIFO with push and pop in the same cycle -> cnt stays 4, ovf=0, new byte is last out.
REQ-038 The bench SHALL cover: a write I/O cycle held 3 clkcpu cycles -> exactly one push.
REQ-039 The bench SHALL cover: gs_out_wr 5Ah -> status bit7=1; B3h read returns 5Ah and then bit7=0; gs_out_wr coincident with the read -> bit7 stays 1.
REQ-040 The bench SHALL cover: BBh write 80h coincident with gs_cmd_ack -> gs_cmd=80h, gs_cmd_valid=1; a later ack alone -> 0.

Source files
------------

// File: rtl/gs_host_mailbox.sv
// rtl/gs_host_mailbox.sv - Z80 host <-> GS mailbox: data FIFO at B3h, command/status at BBh
// Host accesses are edge-detected so each I/O cycle produces exactly one event.
module gs_host_mailbox #(
  parameter int DEPTH = 4
) (
  input  logic       rst_n,
  input  logic       clkcpu,
  input  logic [7:0] a,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic       n_iorq,
  input  logic       n_rd,
  input  logic       n_wr,
  input  logic       n_m1,
  input  logic       ena,
  output logic       iorqge,
  output logic [7:0] gs_data,
  output logic       gs_data_valid,
  input  logic       gs_data_pop,
  output logic [7:0] gs_cmd,
  output logic       gs_cmd_valid,
  input  logic       gs_cmd_ack,
  input  logic       gs_out_wr,
  input  logic [7:0] gs_out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] ADDR_DATA = 8'hB3;
  localparam logic [7:0] ADDR_CMD  = 8'hBB;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, rd_q;
  logic          ovf_q, ovf_d;
  logic          out_flag_q, out_flag_d;
  logic [7:0]    out_q;
  logic [7:0]    cmd_q;
  logic          cmd_valid_q, cmd_valid_d;

  logic wr_qual, rd_qual, wr_ev, rd_ev;
  logic hit_data, hit_cmd;
  logic fifo_full, fifo_empty;
  logic push_req, push, pop;
  logic [3:0] cnt_wide;
  logic [2:0] cnt_field;
  logic [7:0] status;

  assign wr_qual  = ~n_iorq & ~n_wr & n_m1 & ena;
  assign rd_qual  = ~n_iorq & ~n_rd & n_m1 & ena;
  assign wr_ev    = wr_qual & ~wr_q;
  assign rd_ev    = rd_qual & ~rd_q;
  assign hit_data = (a == ADDR_DATA);
  assign hit_cmd  = (a == ADDR_CMD);

  assign fifo_full  = (cnt_q == CW'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = gs_data_pop & ~fifo_empty;
  assign push_req   = wr_ev & hit_data;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push       = push_req & (~fifo_full | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    ovf_d = ovf_q;
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    else if (rd_ev && hit_cmd)         ovf_d = 1'b0;

    out_flag_d = out_flag_q;
    if (gs_out_wr)                out_flag_d = 1'b1;
    else if (rd_ev && hit_data)   out_flag_d = 1'b0;

    cmd_valid_d = cmd_valid_q;
    if (wr_ev && hit_cmd) cmd_valid_d = 1'b1;
    else if (gs_cmd_ack)  cmd_valid_d = 1'b0;
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_flag_q  <= 1'b0;
      out_q       <= 8'h00;
      cmd_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
    end else begin
      wr_q        <= wr_qual;
      rd_q        <= rd_qual;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_flag_q  <= out_flag_d;
      cmd_valid_q <= cmd_valid_d;
      if (push)                wptr_q <= wptr_q + AW'(1);
      if (pop)                 rptr_q <= rptr_q + AW'(1);
      if (gs_out_wr)           out_q  <= gs_out_data;
      if (wr_ev && hit_cmd)    cmd_q  <= d_in;
    end
  end

  always_ff @(posedge clkcpu) begin
    if (push) mem[wptr_q] <= d_in;
  end

  // Count field is 3 bits wide; DEPTH=8 saturates at 7.
  assign cnt_wide  = 4'(cnt_q);
  assign cnt_field = cnt_wide[3] ? 3'd7 : cnt_wide[2:0];
  assign status    = {out_flag_q, fifo_full, ovf_q, cnt_field, ~fifo_empty, cmd_valid_q};

  assign d_out         = hit_data ? out_q : status;
  assign d_oe          = rd_qual & (hit_data | hit_cmd);
  assign iorqge        = ena & (hit_data | hit_cmd);
  assign gs_data       = mem[rptr_q];
  assign gs_data_valid = ~fifo_empty;
  assign gs_cmd        = cmd_q;
  assign gs_cmd_valid  = cmd_valid_q;

endmodule

// File: tb/tb_gs_host_mailbox.sv
// tb/tb_gs_host_mailbox.sv - scoreboard bench for gs_host_mailbox
// Expected host read data and FIFO byte order are queued; a negedge monitor checks them.
module tb_gs_host_mailbox;

  logic       rst_n, clkcpu;
  logic [7:0] a, d_in, d_out, gs_data, gs_cmd, gs_out_data;
  logic       d_oe, n_iorq, n_rd, n_wr, n_m1, ena, iorqge;
  logic       gs_data_valid, gs_data_pop, gs_cmd_valid, gs_cmd_ack, gs_out_wr;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_rd[$];
  logic [7:0] exp_fifo[$];
  int         checks = 0;
  int         failures = 0;
  logic       prev_oe = 1'b0;

  localparam logic [7:0] B3 = 8'hB3;
  localparam logic [7:0] BB = 8'hBB;
  localparam logic [2:0] S_NONE = 3'b000, S_POP = 3'b001, S_ACK = 3'b010, S_OWR = 3'b100;

  gs_host_mailbox #(.DEPTH(4)) dut (
    .rst_n(rst_n), .clkcpu(clkcpu), .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .n_m1(n_m1), .ena(ena), .iorqge(iorqge),
    .gs_data(gs_data), .gs_data_valid(gs_data_valid), .gs_data_pop(gs_data_pop),
    .gs_cmd(gs_cmd), .gs_cmd_valid(gs_cmd_valid), .gs_cmd_ack(gs_cmd_ack),
    .gs_out_wr(gs_out_wr), .gs_out_data(gs_out_data)
  );

  initial clkcpu = 1'b0;
  always #5 clkcpu = ~clkcpu;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  // Host I/O cycle; side pulses {out_wr, ack, pop} are asserted for the first clock only.
  task automatic io_cycle(input bit is_rd, input logic [7:0] addr, input logic [7:0] data,
                          input int hold, input logic [2:0] side);
    a = addr;
    d_in = data;
    n_iorq = 1'b0;
    if (is_rd) n_rd = 1'b0;
    else       n_wr = 1'b0;
    {gs_out_wr, gs_cmd_ack, gs_data_pop} = side;
    @(posedge clkcpu); #1;
    {gs_out_wr, gs_cmd_ack, gs_data_pop} = 3'b000;
    for (int i = 1; i < hold; i++) begin
      @(posedge clkcpu); #1;
    end
    n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    @(posedge clkcpu); #1;
  endtask

  task automatic host_wr(input logic [7:0] addr, input logic [7:0] data, input int hold,
                         input logic [2:0] side);
    io_cycle(1'b0, addr, data, hold, side);
  endtask

  task automatic host_rd(input string name, input logic [7:0] addr, input logic [7:0] exp,
                         input logic [2:0] side);
    exp_t e;
    e.name = name;
    e.val  = exp;
    exp_rd.push_back(e);
    io_cycle(1'b1, addr, 8'h00, 1, side);
  endtask

  task automatic pulse_pop();
    gs_data_pop = 1'b1;
    @(posedge clkcpu); #1;
    gs_data_pop = 1'b0;
  endtask

  task automatic pulse_ack();
    gs_cmd_ack = 1'b1;
    @(posedge clkcpu); #1;
    gs_cmd_ack = 1'b0;
  endtask

  task automatic pulse_outwr(input logic [7:0] v);
    gs_out_data = v;
    gs_out_wr = 1'b1;
    @(posedge clkcpu); #1;
    gs_out_wr = 1'b0;
  endtask

  // Monitor: first cycle of each d_oe assertion consumes one expected read value;
  // every effective pop consumes one expected FIFO byte.
  always @(negedge clkcpu) begin
    if (rst_n) begin
      if (d_oe && !prev_oe) begin
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual=%02h expected=none", d_out);
        end else begin
          exp_t e;
          e = exp_rd.pop_front();
          check8(e.name, d_out, e.val);
        end
      end
      if (gs_data_pop && gs_data_valid) begin
        if (exp_fifo.size() == 0) begin
          checks++; failures++;
          $display("FAIL pop_unexpected actual=%02h expected=none", gs_data);
        end else begin
          check8("pop_data", gs_data, exp_fifo.pop_front());
        end
      end
      prev_oe <= d_oe;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; a = 8'h00; d_in = 8'h00; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    n_m1 = 1'b1; ena = 1'b1; gs_data_pop = 1'b0; gs_cmd_ack = 1'b0;
    gs_out_wr = 1'b0; gs_out_data = 8'h00;
    #12;
    check8("rst_data_valid", {7'd0, gs_data_valid}, 8'h00);
    check8("rst_cmd_valid", {7'd0, gs_cmd_valid}, 8'h00);
    check8("rst_cmd", gs_cmd, 8'h00);
    check8("rst_d_oe", {7'd0, d_oe}, 8'h00);
    @(posedge clkcpu); #1;
    rst_n = 1'b1;
    @(posedge clkcpu); #1;
    host_rd("status_reset", BB, 8'h00, S_NONE);

    // Two bytes in, head and count visible, pop advances head.
    host_wr(B3, 8'h11, 1, S_NONE); exp_fifo.push_back(8'h11);
    host_wr(B3, 8'h22, 1, S_NONE); exp_fifo.push_back(8'h22);
    check8("head_11", gs_data, 8'h11);
    host_rd("status_cnt2", BB, 8'h0A, S_NONE);
    pulse_pop();
    check8("head_22", gs_data, 8'h22);
    pulse_pop();

    // Overflow: fifth byte dropped, ovf cleared by status read, full persists.
    for (int i = 1; i <= 5; i++) begin
      host_wr(B3, 8'(i), 1, S_NONE);
      if (i <= 4) exp_fifo.push_back(8'(i));
    end
    host_rd("status_full_ovf", BB, 8'h72, S_NONE);
    host_rd("status_ovf_clr", BB, 8'h52, S_NONE);

    // Full FIFO: push and pop together, count holds, no overflow.
    host_wr(B3, 8'h06, 1, S_POP); exp_fifo.push_back(8'h06);
    host_rd("status_pushpop", BB, 8'h52, S_NONE);
    repeat (4) pulse_pop();
    check8("empty_after_drain", {7'd0, gs_data_valid}, 8'h00);

    // Held write cycle yields one push only.
    host_wr(B3, 8'hAA, 3, S_NONE); exp_fifo.push_back(8'hAA);
    host_rd("status_held_wr", BB, 8'h06, S_NONE);
    pulse_pop();
    check8("empty_after_held", {7'd0, gs_data_valid}, 8'h00);

    // Disabled block: no decode, no drive, no events.
    ena = 1'b0; a = B3; d_in = 8'h77; n_iorq = 1'b0; n_wr = 1'b0;
    @(posedge clkcpu); #1;
    check8("dis_iorqge", {7'd0, iorqge}, 8'h00);
    n_wr = 1'b1; n_rd = 1'b0; a = BB;
    @(posedge clkcpu); #1;
    check8("dis_d_oe", {7'd0, d_oe}, 8'h00);
    n_iorq = 1'b1; n_rd = 1'b1; ena = 1'b1;
    @(posedge clkcpu); #1;
    check8("en_iorqge", {7'd0, iorqge}, 8'h01);
    host_rd("status_after_dis", BB, 8'h00, S_NONE);

    // GS-to-host byte and its flag.
    pulse_outwr(8'h5A);
    host_rd("status_outflag", BB, 8'h80, S_NONE);
    host_rd("out_5a", B3, 8'h5A, S_NONE);
    host_rd("status_outclr", BB, 8'h00, S_NONE);
    pulse_outwr(8'h5A);
    gs_out_data = 8'h3C;
    host_rd("out_old_coinc", B3, 8'h5A, S_OWR);
    host_rd("status_out_kept", BB, 8'h80, S_NONE);
    host_rd("out_3c", B3, 8'h3C, S_NONE);

    // Command register with coincident ack.
    host_wr(BB, 8'h12, 1, S_NONE);
    check8("cmd_12", gs_cmd, 8'h12);
    host_rd("status_cmd", BB, 8'h01, S_NONE);
    host_wr(BB, 8'h80, 1, S_ACK);
    check8("cmd_80", gs_cmd, 8'h80);
    check8("cmd_valid_coinc", {7'd0, gs_cmd_valid}, 8'h01);
    pulse_ack();
    check8("cmd_valid_ack", {7'd0, gs_cmd_valid}, 8'h00);
    host_rd("status_final", BB, 8'h00, S_NONE);

    repeat (2) @(posedge clkcpu);
    #1;
    check8("rd_queue_left", 8'(exp_rd.size()), 8'h00);
    check8("fifo_queue_left", 8'(exp_fifo.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
